// File: rtl/wide_addsub_sched.sv
// wide_addsub_sched: two-requester round-robin scheduler in front of one
// BLOCK-bit add/sub slice. A granted request's N-bit operands are processed
// one limb per cycle, LSB limb first, with the carry or borrow chained
// between limbs. The result is returned over a valid/ready port.
module wide_addsub_sched #(
  parameter int N     = 4096,
  parameter int BLOCK = 128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_vld,
  output logic         req0_rdy,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic         req0_mode,
  input  logic         req1_vld,
  output logic         req1_rdy,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic         req1_mode,
  output logic         res_vld,
  input  logic         res_rdy,
  output logic         res_id,
  output logic [N-1:0] res_sum,
  output logic         res_cout,
  output logic         busy
);

  localparam int LIMBS = N / BLOCK;
  localparam int CW    = (LIMBS > 1) ? $clog2(LIMBS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_next;
  logic [N-1:0]       a_q, b_q;
  logic               mode_q;
  logic [CW-1:0]      cnt;
  logic               carry;
  logic               last_grant;
  logic               grant_id;
  logic               accept;
  logic               last_limb;
  logic [BLOCK:0]     limb_res;
  logic [N+BLOCK-1:0] sum_wide;

  // Round-robin grant and ready generation; ready is forced low during reset.
  always_comb begin
    grant_id = (req0_vld && req1_vld) ? ~last_grant : req1_vld;
    req0_rdy = rst_n && (state == IDLE) && !grant_id && req0_vld;
    req1_rdy = rst_n && (state == IDLE) &&  grant_id && req1_vld;
    accept   = req0_rdy || req1_rdy;
  end

  // Limb slice: the operand registers are shifted down so the current limb is
  // always at the bottom; the new result limb enters res_sum from the top.
  always_comb begin
    if (mode_q)
      limb_res = {1'b0, a_q[BLOCK-1:0]} + {1'b0, b_q[BLOCK-1:0]} + {{BLOCK{1'b0}}, carry};
    else
      limb_res = {1'b0, a_q[BLOCK-1:0]} - {1'b0, b_q[BLOCK-1:0]} - {{BLOCK{1'b0}}, carry};
    sum_wide  = {limb_res[BLOCK-1:0], res_sum};
    last_limb = (cnt == CW'(LIMBS - 1));
    busy      = (state != IDLE);
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)    state_next = RUN;
      RUN:     if (last_limb) state_next = DONE;
      DONE:    if (res_rdy)   state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Operand capture, limb-serial datapath and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      mode_q     <= 1'b0;
      cnt        <= '0;
      carry      <= 1'b0;
      last_grant <= 1'b1;
      res_vld    <= 1'b0;
      res_id     <= 1'b0;
      res_sum    <= '0;
      res_cout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q        <= grant_id ? req1_a : req0_a;
            b_q        <= grant_id ? req1_b : req0_b;
            mode_q     <= grant_id ? req1_mode : req0_mode;
            res_id     <= grant_id;
            last_grant <= grant_id;
            cnt        <= '0;
            carry      <= 1'b0;
          end
        end
        RUN: begin
          a_q     <= a_q >> BLOCK;
          b_q     <= b_q >> BLOCK;
          res_sum <= sum_wide[N+BLOCK-1:BLOCK];
          carry   <= limb_res[BLOCK];
          cnt     <= cnt + CW'(1);
          if (last_limb) begin
            res_cout <= limb_res[BLOCK];
            res_vld  <= 1'b1;
          end
        end
        DONE: begin
          if (res_rdy) res_vld <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wide_addsub_sched.sv
// Directed and randomized self-checking bench for wide_addsub_sched
// (N=256, BLOCK=64, four limbs).
module tb_wide_addsub_sched;

  localparam int N = 256;
  localparam int BLOCK = 64;

  logic         clk, rst_n;
  logic         req0_vld, req0_rdy, req0_mode;
  logic         req1_vld, req1_rdy, req1_mode;
  logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         res_vld, res_rdy, res_id, res_cout, busy;
  logic [N-1:0] res_sum;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [N-1:0] s;
    logic         c;
    logic         id;
  } exp_t;
  exp_t sb[$];

  wide_addsub_sched #(.N(N), .BLOCK(BLOCK)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_vld(req0_vld), .req0_rdy(req0_rdy), .req0_a(req0_a), .req0_b(req0_b), .req0_mode(req0_mode),
    .req1_vld(req1_vld), .req1_rdy(req1_rdy), .req1_a(req1_a), .req1_b(req1_b), .req1_mode(req1_mode),
    .res_vld(res_vld), .res_rdy(res_rdy), .res_id(res_id), .res_sum(res_sum), .res_cout(res_cout),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] rnd256();
    logic [N-1:0] r;
    for (int i = 0; i < N / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                 input logic mode, input logic id);
    logic [N:0] r;
    exp_t e;
    r = mode ? ({1'b0, a} + {1'b0, b}) : ({1'b0, a} - {1'b0, b});
    e.s = r[N-1:0];
    e.c = r[N];
    e.id = id;
    return e;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req0_vld = 1'b0;
    req1_vld = 1'b0;
    res_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld", res_vld, 0);
    chk("rst_sum", res_sum, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One isolated operation on a single requester, with res_rdy held high.
  task automatic op(input logic id, input logic [N-1:0] a, input logic [N-1:0] b,
                    input logic mode, input string tag, input logic [N-1:0] exp_sum,
                    input logic exp_cout, input logic chk_lat);
    int w;
    int lat;
    @(negedge clk);
    res_rdy = 1'b1;
    if (id) begin req1_a = a; req1_b = b; req1_mode = mode; req1_vld = 1'b1; end
    else    begin req0_a = a; req0_b = b; req0_mode = mode; req0_vld = 1'b1; end
    #1;
    w = 0;
    while (!(id ? req1_rdy : req0_rdy) && w < 50) begin
      @(negedge clk); #1; w++;
    end
    chk({tag, "_acc"}, (w < 50), 1);
    @(posedge clk);
    #1;
    if (id) req1_vld = 1'b0; else req0_vld = 1'b0;
    lat = 0;
    while (!res_vld && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    if (chk_lat) chk({tag, "_lat"}, lat, 4);
    chk({tag, "_sum"}, res_sum, exp_sum);
    chk({tag, "_cout"}, res_cout, exp_cout);
    chk({tag, "_id"}, res_id, id);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [N-1:0] ones;
    logic [N-1:0] p64;
    int n;
    bit seen;

    ones = '1;
    p64 = 256'h1 << 64;
    rst_n = 1'b0;
    req0_vld = 1'b0; req1_vld = 1'b0;
    req0_mode = 1'b0; req1_mode = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    res_rdy = 1'b1;

    do_reset();

    // 1: carry ripples across all limbs
    op(1'b0, ones, 256'd1, 1'b1, "add_ripple", 256'd0, 1'b1, 1'b1);

    // 2: subtraction cases
    op(1'b1, 256'd0, 256'd1, 1'b0, "sub_wrap", ones, 1'b1, 1'b0);
    op(1'b0, 256'd5, 256'd3, 1'b0, "sub_small", 256'd2, 1'b0, 1'b0);
    op(1'b1, p64, 256'd1, 1'b0, "sub_limb", p64 - 256'd1, 1'b0, 1'b1);

    // 3: both requesters held valid from reset alternate 0,1,0,1
    do_reset();
    @(negedge clk);
    req0_a = 256'd1;  req0_b = 256'd2; req0_mode = 1'b1; req0_vld = 1'b1;
    req1_a = 256'd10; req1_b = 256'd3; req1_mode = 1'b0; req1_vld = 1'b1;
    res_rdy = 1'b1;
    n = 0;
    for (int c = 0; c < 200 && n < 4; c++) begin
      @(negedge clk);
      #1;
      chk("arb_excl", (req0_rdy && req1_rdy), 0);
      if (res_vld) begin
        chk("arb_id", res_id, n % 2);
        chk("arb_sum", res_sum, (n % 2) ? 256'd7 : 256'd3);
        n++;
        if (n == 4) begin req0_vld = 1'b0; req1_vld = 1'b0; end
      end
    end
    chk("arb_cnt", n, 4);
    req0_vld = 1'b0; req1_vld = 1'b0;

    // 4: backpressure in DONE, pending req1 accepted after drain
    @(negedge clk);
    res_rdy = 1'b0;
    req0_a = 256'd100; req0_b = 256'd58; req0_mode = 1'b0; req0_vld = 1'b1;
    #1;
    n = 0;
    while (!req0_rdy && n < 50) begin @(negedge clk); #1; n++; end
    chk("bp_acc", (n < 50), 1);
    @(posedge clk);
    #1;
    req1_a = 256'd3; req1_b = 256'd4; req1_mode = 1'b1; req1_vld = 1'b1;
    n = 0;
    while (!res_vld && n < 50) begin @(posedge clk); #1; n++; end
    for (int c = 0; c < 10; c++) begin
      chk("bp_vld", res_vld, 1);
      chk("bp_sum", res_sum, 256'd42);
      chk("bp_cout", res_cout, 0);
      chk("bp_id", res_id, 0);
      chk("bp_rdy", (req0_rdy || req1_rdy), 0);
      @(posedge clk);
      #1;
    end
    res_rdy = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_idle", busy, 0);
    chk("bp_vld_lo", res_vld, 0);
    chk("bp_rdy1", req1_rdy, 1);
    chk("bp_rdy0", req0_rdy, 0);
    @(posedge clk);
    #1;
    chk("bp_busy", busy, 1);
    req0_vld = 1'b0; req1_vld = 1'b0;
    n = 0;
    while (!res_vld && n < 50) begin @(posedge clk); #1; n++; end
    chk("bp2_sum", res_sum, 256'd7);
    chk("bp2_id", res_id, 1);
    @(posedge clk);
    #1;

    // 5: reset while cnt==2 aborts the operation
    @(negedge clk);
    req1_a = ones; req1_b = 256'd5; req1_mode = 1'b1; req1_vld = 1'b1;
    #1;
    n = 0;
    while (!req1_rdy && n < 50) begin @(negedge clk); #1; n++; end
    @(posedge clk);
    #1;
    req1_vld = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    req0_vld = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_vld", res_vld, 0);
    chk("mid_sum", res_sum, 0);
    chk("mid_cout", res_cout, 0);
    chk("mid_id", res_id, 0);
    chk("mid_busy", busy, 0);
    chk("mid_rdy", (req0_rdy || req1_rdy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    req0_vld = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin @(negedge clk); seen |= res_vld; end
    chk("mid_novld", seen, 0);
    op(1'b0, 256'd7, 256'd8, 1'b1, "rst_add", 256'd15, 1'b0, 1'b0);

    // 6: randomized traffic against a full-width reference model
    begin
      int issued = 0;
      int done = 0;
      int cyc = 0;
      bit acc0 = 0;
      bit acc1 = 0;
      exp_t e;
      while (done < 2000 && cyc < 60000) begin
        @(negedge clk);
        cyc++;
        if (acc0) begin req0_vld = 1'b0; acc0 = 0; end
        if (acc1) begin req1_vld = 1'b0; acc1 = 0; end
        for (int r = 0; r < 2; r++) begin
          if (!(r ? req1_vld : req0_vld) && issued < 2000 && $urandom_range(3) == 0) begin
            logic [N-1:0] a, b;
            int k;
            a = rnd256();
            b = rnd256();
            k = $urandom_range(7);
            if (k == 0) b = ~a;
            else if (k == 1) b = a;
            else if (k == 2) a = '1;
            if (r == 1) begin req1_a = a; req1_b = b; req1_mode = $urandom_range(1); req1_vld = 1'b1; end
            else        begin req0_a = a; req0_b = b; req0_mode = $urandom_range(1); req0_vld = 1'b1; end
            issued++;
          end
        end
        res_rdy = ($urandom_range(3) != 0);
        #1;
        if (req0_rdy) begin sb.push_back(model(req0_a, req0_b, req0_mode, 1'b0)); acc0 = 1; end
        if (req1_rdy) begin sb.push_back(model(req1_a, req1_b, req1_mode, 1'b1)); acc1 = 1; end
        if (res_vld && res_rdy) begin
          if (sb.size() == 0) begin
            chk("rnd_extra", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("rnd_sum", res_sum, e.s);
            chk("rnd_cout", res_cout, e.c);
            chk("rnd_id", res_id, e.id);
          end
          done++;
        end
      end
      chk("rnd_done", done, 2000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
